// File: rtl/rem_sign_eval_if.sv
// rtl/rem_sign_eval_if.sv - valid/ready bundle between divide core, remainder-sign evaluator and rounder
interface rem_sign_eval_if #(
  parameter int WIDTH = 28
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   n;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     q;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     q_out;
  logic                 rem_is_positive;
  logic                 rem_is_negative;

  modport master (
    output in_valid, n, d, q, out_ready,
    input  in_ready, out_valid, q_out, rem_is_positive, rem_is_negative
  );

  modport slave (
    input  in_valid, n, d, q, out_ready,
    output in_ready, out_valid, q_out, rem_is_positive, rem_is_negative
  );
endinterface

// File: rtl/rem_sign_eval.sv
// rtl/rem_sign_eval.sv - serial T*d multiply and remainder sign flags for divider rounding
// Evaluates n - T*d and n - M*d where T is q with guard bits cleared and M = T + half an ULP.
module rem_sign_eval #(
  parameter int WIDTH = 28,
  parameter int ULP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rem_sign_eval_if.slave   bus
);

  localparam int NW       = 2 * WIDTH;
  localparam int CW       = $clog2(WIDTH + 1);
  localparam int MUL_LAST = WIDTH - ULP - 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CMP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] qv_q, qv_d;
  logic [NW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pos_q, pos_d;
  logic            neg_q, neg_d;

  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] q_shift;
  logic [NW-1:0]    addend;
  logic [NW:0]      mid_prod;
  logic [NW:0]      rem_t;
  logic [NW:0]      rem_m;

  // Datapath helpers: current partial-product term and both remainders.
  always_comb begin
    bit_idx  = CW'(ULP) + cnt_q;
    q_shift  = qv_q >> bit_idx;
    addend   = {{WIDTH{1'b0}}, d_q} << bit_idx;
    mid_prod = {1'b0, acc_q} + ({{(WIDTH + 1){1'b0}}, d_q} << (ULP - 1));
    rem_t    = {1'b0, n_q} - {1'b0, acc_q};
    rem_m    = {1'b0, n_q} - mid_prod;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    qv_d    = qv_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    neg_d   = neg_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          n_d     = bus.n;
          d_d     = bus.d;
          qv_d    = bus.q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (q_shift[0]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_LAST)) begin
          state_d = CMP;
        end
      end
      CMP: begin
        // A zero remainder leaves both flags clear, so a tie never rounds up.
        neg_d   = rem_t[NW];
        pos_d   = !rem_m[NW] && (rem_m != '0);
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      qv_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      qv_q    <= qv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.out_valid       = (state_q == DONE);
  assign bus.q_out           = qv_q;
  assign bus.rem_is_positive = pos_q;
  assign bus.rem_is_negative = neg_q;

endmodule

// File: tb/tb_rem_sign_eval.sv
// tb/tb_rem_sign_eval.sv - table-driven scoreboard bench for rem_sign_eval
module tb_rem_sign_eval;

  localparam int WIDTH = 28;
  localparam int ULP   = 4;
  localparam int LAT   = WIDTH - ULP + 1;

  typedef struct {
    logic [2*WIDTH-1:0] n;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   q;
    logic               pos;
    logic               neg;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             pos;
    logic             neg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];
  exp_t sb[$];

  rem_sign_eval_if #(.WIDTH(WIDTH)) bus ();

  rem_sign_eval #(.WIDTH(WIDTH), .ULP(ULP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: direct wide multiplication, not the serial shift-add.
  function automatic void model(input logic [55:0] n, input logic [27:0] d, input logic [27:0] q,
                                output logic pos, output logic neg);
    logic [63:0] t;
    logic [63:0] prod;
    logic [63:0] mid;
    t    = {36'd0, q[27:4], 4'd0};
    prod = t * {36'd0, d};
    mid  = prod + ({36'd0, d} << 3);
    pos  = ({8'd0, n} > mid);
    neg  = ({8'd0, n} < prod);
  endfunction

  function automatic void add_vec(input logic [55:0] n, input logic [27:0] d, input logic [27:0] q,
                                  input logic pos, input logic neg);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.pos = pos; v.neg = neg;
    vecs.push_back(v);
  endfunction

  function automatic void add_model_vec(input logic [55:0] n, input logic [27:0] d, input logic [27:0] q);
    logic p, g;
    model(n, d, q, p, g);
    add_vec(n, d, q, p, g);
  endfunction

  task automatic run_op(input vec_t v, input int bp_cycles);
    exp_t e;
    int   lat;
    bit   got;
    bus.out_ready = (bp_cycles == 0);
    check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.n = v.n; bus.d = v.d; bus.q = v.q; bus.in_valid = 1'b1;
    @(posedge clk);
    e.q = v.q; e.pos = v.pos; e.neg = v.neg;
    sb.push_back(e);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.n = {$urandom, $urandom};
      bus.d = 28'($urandom);
      bus.q = 28'($urandom);
      @(posedge clk);
      #1 lat++;
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("latency", 64'(lat), 64'(LAT));
    if (!got) begin
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check("q_out", 64'(bus.q_out), 64'(e.q));
    check("rem_is_positive", {63'd0, bus.rem_is_positive}, {63'd0, e.pos});
    check("rem_is_negative", {63'd0, bus.rem_is_negative}, {63'd0, e.neg});
    if (bp_cycles > 0) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < bp_cycles; i++) begin
        @(posedge clk);
        #1;
        check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("bp_q_out", 64'(bus.q_out), 64'(e.q));
        check("bp_flags", {62'd0, bus.rem_is_positive, bus.rem_is_negative}, {62'd0, e.pos, e.neg});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    logic [55:0] d1;
    logic [55:0] big;
    vec_t        v;
    logic [27:0] rd, rq;
    logic [63:0] rp;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.n = '0; bus.d = '0; bus.q = '0;

    d1 = 56'd1 << 27;
    add_vec(20 * d1, 28'h8000000, 28'h10, 1'b0, 1'b0);
    add_vec(28 * d1, 28'h8000000, 28'h10, 1'b1, 1'b0);
    add_vec(24 * d1, 28'h8000000, 28'h10, 1'b0, 1'b0);
    add_vec(12 * d1, 28'h8000000, 28'h17, 1'b0, 1'b1);
    add_vec(56'd49, 28'd3, 28'h10, 1'b0, 1'b0);
    add_vec(56'd47, 28'd3, 28'h10, 1'b0, 1'b1);
    add_vec(56'd73, 28'd3, 28'h10, 1'b1, 1'b0);
    add_vec(56'd72, 28'd3, 28'h10, 1'b0, 1'b0);
    big = '1;
    add_model_vec(big, 28'hFFFFFFF, 28'hFFFFFFF);
    add_model_vec(56'd0, 28'hFFFFFFF, 28'hFFFFFFF);
    add_vec(56'hFFFFFEF0000010, 28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 1'b0);
    add_vec(56'hFFFFFEF000000F, 28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rd = 28'($urandom) | 28'd1;
      rq = 28'($urandom);
      rp = {36'd0, rq[27:4], 4'd0} * {36'd0, rd};
      rp = rp + 64'($urandom_range(0, 16)) * {36'd0, rd} / 64'd2 - 64'($urandom_range(0, 3));
      add_model_vec(rp[55:0], rd, rq);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_q_out", 64'(bus.q_out), 64'd0);
    check("reset_flags", {62'd0, bus.rem_is_positive, bus.rem_is_negative}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i], 0);
    end

    run_op(vecs[1], 10);

    v = vecs[0];
    bus.out_ready = 1'b1;
    bus.n = v.n; bus.d = v.d; bus.q = v.q; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midmul_rst_flags", {62'd0, bus.rem_is_positive, bus.rem_is_negative}, 64'd0);
    check("midmul_rst_q_out", 64'(bus.q_out), 64'd0);
    check("midmul_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(vecs[0], 0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
